fpsub_seq: RTL and testbench

- Multi-cycle sequential IEEE-754 single-precision subtractor that computes S = A - B.
- It uses the same 1/8/23 format and the same no-denormal, truncating arithmetic as the team's combinational adder.
- Alignment and normalization are iterative, one bit per cycle, which trades latency for area.
- Operands enter on a start/ready handshake. The result is flagged by a one-cycle done pulse and held until the next operation.

---
 rtl/fpsub_seq.sv | 191 +++++++++++++++++++
 tb/tb_fpsub_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpsub_seq.sv
// Multi-cycle IEEE-754 single-precision subtractor, S = A - B.
// No denormals (exp=0 reads as zero), truncating alignment, and one-bit-per-cycle
// alignment and normalisation. Operands enter on a start/ready handshake, and the
// result is held after a one-cycle done pulse.
module fpsub_seq #(
    parameter int SHIFT_CAP = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        ready,
    output logic        done,
    output logic [31:0] S
);

    localparam logic [31:0] QNAN = 32'hFFC00000;

    typedef enum logic [2:0] {
        ST_IDLE, ST_UNPACK, ST_ALIGN, ST_ADD, ST_NORM, ST_DONE
    } state_t;

    state_t      r_state, w_state_next;
    logic [31:0] r_a, r_b;            // r_b already carries the inverted sign
    logic        r_big_s, r_sml_s, r_sign;
    logic [23:0] r_big_m, r_sml_m, r_mag;
    logic [7:0]  r_exp, r_cnt;
    logic [31:0] r_s;

    // Operand classification during UNPACK
    logic       w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [7:0] w_ea, w_eb, w_d, w_cnt_init;
    logic       w_a_big;
    assign w_sa       = r_a[31];
    assign w_sb       = r_b[31];
    assign w_ea       = r_a[30:23];
    assign w_eb       = r_b[30:23];
    assign w_a_nan    = (w_ea == 8'hFF) && (r_a[22:0] != 23'd0);
    assign w_b_nan    = (w_eb == 8'hFF) && (r_b[22:0] != 23'd0);
    assign w_a_inf    = (w_ea == 8'hFF) && (r_a[22:0] == 23'd0);
    assign w_b_inf    = (w_eb == 8'hFF) && (r_b[22:0] == 23'd0);
    assign w_a_zero   = (w_ea == 8'd0);
    assign w_b_zero   = (w_eb == 8'd0);
    assign w_a_big    = (w_ea >= w_eb);
    assign w_d        = w_a_big ? (w_ea - w_eb) : (w_eb - w_ea);
    assign w_cnt_init = (w_d > 8'(SHIFT_CAP)) ? 8'(SHIFT_CAP) : w_d;

    logic        w_spec_hit;
    logic [31:0] w_spec_res;

    // Special-operand resolution, in priority order: NaN, infinities, zeros
    always_comb begin
        w_spec_hit = 1'b1;
        w_spec_res = 32'd0;
        if (w_a_nan || w_b_nan)
            w_spec_res = QNAN;
        else if (w_a_inf && w_b_inf)
            w_spec_res = (w_sa != w_sb) ? QNAN : {w_sa, 8'hFF, 23'd0};
        else if (w_a_inf)
            w_spec_res = {w_sa, 8'hFF, 23'd0};
        else if (w_b_inf)
            w_spec_res = {w_sb, 8'hFF, 23'd0};
        else if (w_a_zero && w_b_zero)
            w_spec_res = {w_sa & w_sb, 31'd0};
        else if (w_a_zero)
            w_spec_res = r_b;
        else if (w_b_zero)
            w_spec_res = r_a;
        else
            w_spec_hit = 1'b0;
    end

    // Signed-magnitude add in a 26-bit two's-complement datapath
    logic [25:0] w_big_v, w_sml_v, w_sum, w_abs;
    logic        w_sum_zero, w_carry, w_add_ovf, w_add_norm;
    logic [23:0] w_add_mag;
    logic [8:0]  w_add_exp;
    assign w_big_v    = r_big_s ? (26'd0 - {2'b00, r_big_m}) : {2'b00, r_big_m};
    assign w_sml_v    = r_sml_s ? (26'd0 - {2'b00, r_sml_m}) : {2'b00, r_sml_m};
    assign w_sum      = w_big_v + w_sml_v;
    assign w_abs      = w_sum[25] ? (26'd0 - w_sum) : w_sum;
    assign w_sum_zero = (w_abs == 26'd0);
    assign w_carry    = w_abs[24];
    assign w_add_mag  = w_carry ? w_abs[24:1] : w_abs[23:0];
    assign w_add_exp  = {1'b0, r_exp} + {8'd0, w_carry};
    assign w_add_ovf  = (w_add_exp == 9'd255);
    assign w_add_norm = w_add_mag[23];

    // One normalisation step per NORM cycle
    logic [23:0] w_norm_mag;
    logic [7:0]  w_norm_exp;
    logic        w_norm_flush, w_norm_ok;
    assign w_norm_mag   = r_mag << 1;
    assign w_norm_exp   = r_exp - 8'd1;
    assign w_norm_flush = (w_norm_exp == 8'd0);
    assign w_norm_ok    = w_norm_mag[23];

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (start) w_state_next = ST_UNPACK;
            ST_UNPACK: begin
                if (w_spec_hit)        w_state_next = ST_DONE;
                else if (w_d != 8'd0)  w_state_next = ST_ALIGN;
                else                   w_state_next = ST_ADD;
            end
            ST_ALIGN:  if (r_cnt == 8'd1) w_state_next = ST_ADD;
            ST_ADD: begin
                if (w_sum_zero || w_add_ovf || w_add_norm) w_state_next = ST_DONE;
                else                                       w_state_next = ST_NORM;
            end
            ST_NORM:   if (w_norm_flush || w_norm_ok) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        ready = (r_state == ST_IDLE);
        done  = (r_state == ST_DONE);
    end

    assign S = r_s;

    // Datapath registers: capture, unpack, align, add, normalise
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_big_s <= 1'b0;
            r_sml_s <= 1'b0;
            r_big_m <= 24'd0;
            r_sml_m <= 24'd0;
            r_sign  <= 1'b0;
            r_mag   <= 24'd0;
            r_exp   <= 8'd0;
            r_cnt   <= 8'd0;
            r_s     <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a <= A;
                        r_b <= {~B[31], B[30:0]};
                    end
                end
                ST_UNPACK: begin
                    if (w_spec_hit) begin
                        r_s <= w_spec_res;
                    end else begin
                        r_big_s <= w_a_big ? w_sa : w_sb;
                        r_sml_s <= w_a_big ? w_sb : w_sa;
                        r_big_m <= w_a_big ? {1'b1, r_a[22:0]} : {1'b1, r_b[22:0]};
                        r_sml_m <= w_a_big ? {1'b1, r_b[22:0]} : {1'b1, r_a[22:0]};
                        r_exp   <= w_a_big ? w_ea : w_eb;
                        r_cnt   <= w_cnt_init;
                    end
                end
                ST_ALIGN: begin
                    r_sml_m <= r_sml_m >> 1;
                    r_cnt   <= r_cnt - 8'd1;
                end
                ST_ADD: begin
                    r_sign <= w_sum[25];
                    r_mag  <= w_add_mag;
                    r_exp  <= w_add_exp[7:0];
                    if (w_sum_zero)      r_s <= 32'd0;
                    else if (w_add_ovf)  r_s <= {w_sum[25], 8'hFF, 23'd0};
                    else if (w_add_norm) r_s <= {w_sum[25], w_add_exp[7:0], w_add_mag[22:0]};
                end
                ST_NORM: begin
                    r_mag <= w_norm_mag;
                    r_exp <= w_norm_exp;
                    if (w_norm_flush)   r_s <= {r_sign, 31'd0};
                    else if (w_norm_ok) r_s <= {r_sign, w_norm_exp, w_norm_mag[22:0]};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpsub_seq.sv
// Testbench for fpsub_seq: directed cases, special operands, control corners and
// randomized operands checked against a behavioural model of A - B.
module tb_fpsub_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        ready, done;
    logic [31:0] S;

    int checks = 0;
    int errors = 0;

    fpsub_seq #(.SHIFT_CAP(26)) dut (
        .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
        .ready(ready), .done(done), .S(S)
    );

    always #5 clk = ~clk;

    // Behavioural model: result and latency (accepting edge counts as cycle 1)
    function automatic void ref_sub(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] s, output int lat);
        logic sa, sb, sg;
        int   ea, eb, ma, mb, d, k, vbig, vsml, sum, mag, e, n;
        logic [31:0] magv;
        logic [7:0]  e8;
        sa = a[31];
        sb = ~b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        lat = 2;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) begin
            s = 32'hFFC00000; return;
        end
        if (ea == 255 && eb == 255) begin
            s = (sa != sb) ? 32'hFFC00000 : {sa, 8'hFF, 23'd0}; return;
        end
        if (ea == 255) begin s = {sa, 8'hFF, 23'd0}; return; end
        if (eb == 255) begin s = {sb, 8'hFF, 23'd0}; return; end
        if (ea == 0 && eb == 0) begin s = {sa & sb, 31'd0}; return; end
        if (ea == 0) begin s = {sb, b[30:0]}; return; end
        if (eb == 0) begin s = a; return; end
        ma = int'({1'b1, a[22:0]});
        mb = int'({1'b1, b[22:0]});
        if (ea >= eb) begin
            d = ea - eb; e = ea;
            k = (d > 26) ? 26 : d;
            vbig = sa ? -ma : ma;
            vsml = sb ? -(mb >> k) : (mb >> k);
        end else begin
            d = eb - ea; e = eb;
            k = (d > 26) ? 26 : d;
            vbig = sb ? -mb : mb;
            vsml = sa ? -(ma >> k) : (ma >> k);
        end
        sum = vbig + vsml;
        lat = 3 + k;
        if (sum == 0) begin s = 32'd0; return; end
        sg  = (sum < 0);
        mag = sg ? -sum : sum;
        if (mag >= (1 << 24)) begin
            mag = mag >> 1;
            e = e + 1;
            if (e >= 255) begin s = {sg, 8'hFF, 23'd0}; return; end
        end
        n = 0;
        while (mag < (1 << 23)) begin
            mag = mag << 1;
            e = e - 1;
            n++;
            if (e == 0) begin s = {sg, 31'd0}; lat = lat + n; return; end
        end
        lat  = lat + n;
        magv = mag;
        e8   = e[7:0];
        s = {sg, e8, magv[22:0]};
    endfunction

    // Runs one operation; lat=-1 when done never arrives. Optionally pulses a
    // stray start with junk operands in cycle glitch_k of the operation.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int glitch_k,
                         output logic [31:0] s, output int lat);
        int k;
        s = 32'hxxxxxxxx;
        lat = -1;
        for (int w = 0; w < 50 && !ready; w++) @(negedge clk);
        @(negedge clk);
        while (!ready) @(negedge clk);
        A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        for (int i = 0; i < 300; i++) begin
            if (k == glitch_k) begin
                start = 1'b1; A = $urandom; B = $urandom;
            end
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (done) begin lat = k; s = S; break; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || S !== 32'd0) begin
            errors++;
            $display("FAIL reset: ready=%b done=%b S=%h, required ready=1 done=0 S=00000000", ready, done, S);
        end
        @(negedge clk); reset = 1'b0;
        $display("reset: ready=%b done=%b S=%h", ready, done, S);
    endtask

    task automatic test_directed();
        logic [31:0] va[5] = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h53800000};
        logic [31:0] vb[5] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800001, 32'h3F800000};
        logic [31:0] vs[5] = '{32'h40000000, 32'h00000000, 32'h40000000, 32'hB4000000, 32'h53800000};
        int          vl[5] = '{4, 3, 3, 26, 29};
        logic [31:0] s;
        int lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], 0, s, lat);
            checks++;
            if (s !== vs[i] || lat != vl[i]) begin
                errors++;
                $display("FAIL directed%0d: A=%h B=%h S=%h lat=%0d, required S=%h lat=%0d",
                         i, va[i], vb[i], s, lat, vs[i], vl[i]);
            end else
                $display("directed%0d: A=%h B=%h S=%h lat=%0d", i, va[i], vb[i], s, lat);
        end
    endtask

    task automatic test_special();
        logic [31:0] va[4] = '{32'h7F800000, 32'h7F800000, 32'h7FC00001, 32'h80000000};
        logic [31:0] vb[4] = '{32'h7F800000, 32'hFF800000, 32'h12345678, 32'h00000000};
        logic [31:0] vs[4] = '{32'hFFC00000, 32'h7F800000, 32'hFFC00000, 32'h80000000};
        logic [31:0] s;
        int lat;
        for (int i = 0; i < 4; i++) begin
            do_op(va[i], vb[i], 0, s, lat);
            checks++;
            if (s !== vs[i] || lat != 2) begin
                errors++;
                $display("FAIL special%0d: A=%h B=%h S=%h lat=%0d, required S=%h lat=2",
                         i, va[i], vb[i], s, lat, vs[i]);
            end else
                $display("special%0d: A=%h B=%h S=%h lat=%0d", i, va[i], vb[i], s, lat);
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] s;
        int lat;
        do_op(32'h53800000, 32'h3F800000, 5, s, lat);
        checks++;
        if (s !== 32'h53800000 || lat != 29) begin
            errors++;
            $display("FAIL start_ignored: S=%h lat=%0d, required S=53800000 lat=29", s, lat);
        end else
            $display("start_ignored: S=%h lat=%0d", s, lat);
    endtask

    task automatic test_back_to_back();
        logic [31:0] s;
        int lat;
        do_op(32'h40400000, 32'h3F800000, 0, s, lat);
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1 || S !== 32'h40000000) begin
            errors++;
            $display("FAIL after_done: done=%b ready=%b S=%h, required done=0 ready=1 S=40000000", done, ready, S);
        end
        // Drive in the same cycle (the one right after done) and expect acceptance
        A = 32'h3F800000; B = 32'hBF800000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back_accept: ready=%b, required 0", ready);
        end
        lat = -1;
        for (int k = 2; k < 50; k++) begin
            @(posedge clk); #1;
            if (done) begin lat = k; break; end
        end
        checks++;
        if (S !== 32'h40000000 || lat != 3) begin
            errors++;
            $display("FAIL back_to_back: S=%h lat=%0d, required S=40000000 lat=3", S, lat);
        end else
            $display("back_to_back: S=%h lat=%0d", S, lat);
    endtask

    task automatic test_reset_mid_norm();
        int seen = 0;
        @(negedge clk);
        while (!ready) @(negedge clk);
        A = 32'h3F800000; B = 32'h3F800001; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || S !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_norm: ready=%b done=%b S=%h, required ready=1 done=0 S=00000000", ready, done, S);
        end else
            $display("reset_mid_norm: ready=%b done=%b S=%h", ready, done, S);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: pulses=%0d, required 0", seen);
        end
    endtask

    function automatic logic [31:0] gen_operand(input int near_exp);
        int r, e;
        r = $urandom_range(0, 15);
        if (r == 0) return {1'($urandom), 8'd0, 23'($urandom)};
        if (r == 1) return {1'($urandom), 8'hFF, 23'd0};
        if (r == 2) return {1'($urandom), 8'hFF, 23'($urandom_range(1, 100))};
        if (near_exp > 0 && r < 12) begin
            e = near_exp + $urandom_range(0, 6) - 3;
            if (e < 1) e = 1;
            if (e > 254) e = 254;
        end else
            e = $urandom_range(1, 254);
        return {1'($urandom), 8'(e), 23'($urandom)};
    endfunction

    task automatic test_random();
        logic [31:0] a, b, s, exp_s;
        int lat, exp_lat;
        for (int i = 0; i < 60; i++) begin
            a = gen_operand(0);
            b = gen_operand(int'(a[30:23]));
            if (i % 5 == 0) b = {$urandom_range(0, 1) == 1 ? 1'b1 : 1'b0, a[30:0] ^ 31'($urandom_range(0, 7))};
            ref_sub(a, b, exp_s, exp_lat);
            do_op(a, b, 0, s, lat);
            checks++;
            if (s !== exp_s || lat != exp_lat) begin
                errors++;
                $display("FAIL random%0d: A=%h B=%h S=%h lat=%0d, required S=%h lat=%0d",
                         i, a, b, s, lat, exp_s, exp_lat);
            end else
                $display("random%0d: A=%h B=%h S=%h lat=%0d", i, a, b, s, lat);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_special();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_norm();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
